// File: rtl/csi_lane_deskew_merge_if.sv
// Lane inputs and merged-word outputs of csi_lane_deskew_merge.
// byte_count is present only when LANE_DESKEW_BYTECOUNT_EN is defined.
interface csi_lane_deskew_merge_if;
   logic [7:0]  lane0_byte;
   logic        lane0_valid;
   logic        lane0_sync;
   logic [7:0]  lane1_byte;
   logic        lane1_valid;
   logic        lane1_sync;
   logic [15:0] word_o;
   logic        word_valid;
   logic        aligned;
   logic        deskew_err;
   logic [2:0]  skew_o;
   logic        lead_lane;
`ifdef LANE_DESKEW_BYTECOUNT_EN
   logic [15:0] byte_count;
`endif

   modport master (
`ifdef LANE_DESKEW_BYTECOUNT_EN
      input  byte_count,
`endif
      output lane0_byte, lane0_valid, lane0_sync, lane1_byte, lane1_valid, lane1_sync,
      input  word_o, word_valid, aligned, deskew_err, skew_o, lead_lane
   );

   modport slave (
`ifdef LANE_DESKEW_BYTECOUNT_EN
      output byte_count,
`endif
      input  lane0_byte, lane0_valid, lane0_sync, lane1_byte, lane1_valid, lane1_sync,
      output word_o, word_valid, aligned, deskew_err, skew_o, lead_lane
   );
endinterface

// File: rtl/csi_lane_deskew_merge.sv
// Measures 2-lane HS sync skew, buffers the leading lane and emits {lane1, lane0} words.
// Define LANE_DESKEW_BYTECOUNT_EN to add the saturating byte_count output.
module csi_lane_deskew_merge #(
   parameter int unsigned MAX_SKEW   = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                    sync_mipi_clk_2,
   input logic                    reset,
   input logic                    stop,
   csi_lane_deskew_merge_if.slave lanes
);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StWait, StAligned, StError} state_e;

   state_e          state_q;
   logic            sync0_q, sync1_q;
   logic            seen0_q, seen1_q;
   logic [2:0]      cnt_q;
   logic [7:0]      mem0_q [FIFO_DEPTH];
   logic [7:0]      mem1_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr0_q, rd0_q, wr1_q, rd1_q;
   logic [CntW-1:0] fill0_q, fill1_q;

   logic       flush;
   logic       rise0, rise1, other_rise;
   logic       pop, req0, req1, ovf0, ovf1, push0, push1;
   logic [3:0] cnt_inc;

   assign flush      = reset | stop;
   assign rise0      = lanes.lane0_sync & ~sync0_q;
   assign rise1      = lanes.lane1_sync & ~sync1_q;
   assign other_rise = lanes.lead_lane ? rise0 : rise1;
   assign cnt_inc    = {1'b0, cnt_q} + 4'd1;

   assign pop   = (state_q == StAligned) && (fill0_q != '0) && (fill1_q != '0);
   // A lane's own sync edge enables its pushes in the same cycle.
   assign req0  = lanes.lane0_valid && (seen0_q || rise0) && (state_q != StError);
   assign req1  = lanes.lane1_valid && (seen1_q || rise1) && (state_q != StError);
   assign ovf0  = req0 && (fill0_q == CntW'(FIFO_DEPTH)) && !pop;
   assign ovf1  = req1 && (fill1_q == CntW'(FIFO_DEPTH)) && !pop;
   assign push0 = req0 && !ovf0;
   assign push1 = req1 && !ovf1;

   always_ff @(posedge sync_mipi_clk_2) begin
      if (push0) mem0_q[wr0_q] <= lanes.lane0_byte;
      if (push1) mem1_q[wr1_q] <= lanes.lane1_byte;
   end

   always_ff @(posedge sync_mipi_clk_2) begin
      if (flush) begin
         wr0_q   <= '0;
         rd0_q   <= '0;
         fill0_q <= '0;
         wr1_q   <= '0;
         rd1_q   <= '0;
         fill1_q <= '0;
      end else begin
         if (push0) wr0_q <= wr0_q + PtrW'(1);
         if (push1) wr1_q <= wr1_q + PtrW'(1);
         if (pop) begin
            rd0_q <= rd0_q + PtrW'(1);
            rd1_q <= rd1_q + PtrW'(1);
         end
         fill0_q <= fill0_q + CntW'(push0) - CntW'(pop);
         fill1_q <= fill1_q + CntW'(push1) - CntW'(pop);
      end
   end

   always_ff @(posedge sync_mipi_clk_2) begin
      if (flush) begin
         state_q          <= StIdle;
         sync0_q          <= 1'b0;
         sync1_q          <= 1'b0;
         seen0_q          <= 1'b0;
         seen1_q          <= 1'b0;
         cnt_q            <= '0;
         lanes.word_o     <= '0;
         lanes.word_valid <= 1'b0;
         lanes.aligned    <= 1'b0;
         lanes.deskew_err <= 1'b0;
         lanes.skew_o     <= '0;
         lanes.lead_lane  <= 1'b0;
      end else begin
         sync0_q          <= lanes.lane0_sync;
         sync1_q          <= lanes.lane1_sync;
         seen0_q          <= seen0_q | rise0;
         seen1_q          <= seen1_q | rise1;
         lanes.word_valid <= pop;
         if (pop) lanes.word_o <= {mem1_q[rd1_q], mem0_q[rd0_q]};
         if (ovf0 || ovf1) begin
            state_q          <= StError;
            lanes.aligned    <= 1'b0;
            lanes.deskew_err <= 1'b1;
         end else begin
            case (state_q)
               StIdle: begin
                  if (rise0 && rise1) begin
                     state_q         <= StAligned;
                     lanes.aligned   <= 1'b1;
                     lanes.skew_o    <= '0;
                     lanes.lead_lane <= 1'b0;
                  end else if (rise0 || rise1) begin
                     state_q         <= StWait;
                     lanes.lead_lane <= rise1;
                     cnt_q           <= '0;
                  end
               end
               StWait: begin
                  if (other_rise) begin
                     state_q       <= StAligned;
                     lanes.aligned <= 1'b1;
                     lanes.skew_o  <= cnt_inc[3] ? 3'd7 : cnt_inc[2:0];
                  end else if (cnt_inc >= 4'(MAX_SKEW)) begin
                     state_q          <= StError;
                     lanes.deskew_err <= 1'b1;
                  end else begin
                     cnt_q <= cnt_inc[2:0];
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef LANE_DESKEW_BYTECOUNT_EN
   logic [16:0] bc_sum;
   assign bc_sum = {1'b0, lanes.byte_count} + 17'd2;

   always_ff @(posedge sync_mipi_clk_2) begin
      if (flush) begin
         lanes.byte_count <= '0;
      end else if (pop) begin
         lanes.byte_count <= bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
      end
   end
`endif
endmodule

// File: tb/tb_csi_lane_deskew_merge.sv
// Bench for csi_lane_deskew_merge: vector table, directed corner sequences and random
// episodes checked against a queue-based reference model.
module tb_csi_lane_deskew_merge;
   localparam int MaxSkew = 2;
   localparam int Depth   = 4;

   logic clk = 1'b0;
   logic reset;
   logic stop;
   int   n_cmp = 0;
   int   n_bad = 0;

   csi_lane_deskew_merge_if bus();

   csi_lane_deskew_merge #(
      .MAX_SKEW  (MaxSkew),
      .FIFO_DEPTH(Depth)
   ) dut (
      .sync_mipi_clk_2(clk),
      .reset          (reset),
      .stop           (stop),
      .lanes          (bus)
   );

   always #5 clk = ~clk;

   // Reference model: phases 0 idle, 1 waiting for second lane, 2 aligned, 3 error.
   int          ph, cyc, lead_cyc;
   logic [7:0]  q0[$], q1[$];
   bit          p0, p1, seen0, seen1;
   logic [15:0] m_word;
   logic        m_wv, m_al, m_err, m_lead;
   logic [2:0]  m_skew;
`ifdef LANE_DESKEW_BYTECOUNT_EN
   int          m_bc;
`endif

   typedef struct {
      logic        stp;
      logic        v0;
      logic [7:0]  b0;
      logic        s0;
      logic        v1;
      logic [7:0]  b1;
      logic        s1;
      logic        wv;
      logic [15:0] w;
      logic        al;
      logic        err;
      logic [2:0]  skew;
      logic        lead;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic stp, input logic v0, input logic [7:0] b0,
                               input logic s0, input logic v1, input logic [7:0] b1,
                               input logic s1, input logic wv, input logic [15:0] w,
                               input logic al, input logic err, input logic [2:0] skew,
                               input logic lead);
      vec_t v;
      v.stp = stp; v.v0 = v0; v.b0 = b0; v.s0 = s0; v.v1 = v1; v.b1 = b1; v.s1 = s1;
      v.wv = wv; v.w = w; v.al = al; v.err = err; v.skew = skew; v.lead = lead;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic stp, input logic v0, input logic [7:0] b0, input logic s0,
                        input logic v1, input logic [7:0] b1, input logic s1);
      stop = stp;
      bus.lane0_valid = v0; bus.lane0_byte = b0; bus.lane0_sync = s0;
      bus.lane1_valid = v1; bus.lane1_byte = b1; bus.lane1_sync = s1;
   endtask

   task automatic model_edge();
      bit r0, r1, pop, ovf;
      logic [7:0] x0, x1;
      cyc++;
      if (reset || stop) begin
         ph = 0; q0.delete(); q1.delete();
         p0 = 0; p1 = 0; seen0 = 0; seen1 = 0;
         m_word = '0; m_wv = 0; m_al = 0; m_err = 0; m_skew = '0; m_lead = 0;
`ifdef LANE_DESKEW_BYTECOUNT_EN
         m_bc = 0;
`endif
         return;
      end
      r0 = bus.lane0_sync && !p0;
      r1 = bus.lane1_sync && !p1;
      p0 = bus.lane0_sync;
      p1 = bus.lane1_sync;
      pop = (ph == 2) && (q0.size() > 0) && (q1.size() > 0);
      m_wv = pop;
      if (pop) begin
         x0 = q0.pop_front();
         x1 = q1.pop_front();
         m_word = {x1, x0};
`ifdef LANE_DESKEW_BYTECOUNT_EN
         m_bc = (m_bc + 2 > 65535) ? 65535 : m_bc + 2;
`endif
      end
      ovf = 0;
      if (ph != 3) begin
         if (bus.lane0_valid && (seen0 || r0)) begin
            if (q0.size() >= Depth) ovf = 1;
            else q0.push_back(bus.lane0_byte);
         end
         if (bus.lane1_valid && (seen1 || r1)) begin
            if (q1.size() >= Depth) ovf = 1;
            else q1.push_back(bus.lane1_byte);
         end
      end
      seen0 = seen0 || r0;
      seen1 = seen1 || r1;
      if (ovf) begin
         ph = 3; m_err = 1; m_al = 0;
      end else if (ph == 0) begin
         if (r0 && r1) begin
            ph = 2; m_al = 1; m_skew = 3'd0; m_lead = 0;
         end else if (r0 || r1) begin
            ph = 1; m_lead = r1; lead_cyc = cyc;
         end
      end else if (ph == 1) begin
         if (m_lead ? r0 : r1) begin
            ph = 2; m_al = 1;
            m_skew = 3'((cyc - lead_cyc > 7) ? 7 : cyc - lead_cyc);
         end else if (cyc - lead_cyc >= MaxSkew) begin
            ph = 3; m_err = 1;
         end
      end
   endtask

   task automatic compare_model();
      check("mdl.word_valid", 32'(bus.word_valid), 32'(m_wv));
      check("mdl.word_o", 32'(bus.word_o), 32'(m_word));
      check("mdl.aligned", 32'(bus.aligned), 32'(m_al));
      check("mdl.deskew_err", 32'(bus.deskew_err), 32'(m_err));
      check("mdl.skew_o", 32'(bus.skew_o), 32'(m_skew));
      check("mdl.lead_lane", 32'(bus.lead_lane), 32'(m_lead));
`ifdef LANE_DESKEW_BYTECOUNT_EN
      check("mdl.byte_count", 32'(bus.byte_count), 32'(m_bc));
`endif
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".word_o"}, 32'(bus.word_o), 32'h0);
      check({tag, ".word_valid"}, 32'(bus.word_valid), 32'h0);
      check({tag, ".aligned"}, 32'(bus.aligned), 32'h0);
      check({tag, ".deskew_err"}, 32'(bus.deskew_err), 32'h0);
      check({tag, ".skew_o"}, 32'(bus.skew_o), 32'h0);
      check({tag, ".lead_lane"}, 32'(bus.lead_lane), 32'h0);
   endtask

   initial begin
      cyc = 0;
      lead_cyc = 0;
      reset = 1'b1;
      drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
      step();
      check_all_zero("reset");
      reset = 1'b0;

      // Same-cycle sync, lane0-leads by 2, lane1-leads by 1.
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 3'd0, 0));
      vecs.push_back(mk(0, 1, 8'h2A, 1, 1, 8'h02, 1, 0, 16'h0000, 1, 0, 3'd0, 0));
      vecs.push_back(mk(0, 1, 8'h80, 1, 1, 8'h00, 1, 1, 16'h022A, 1, 0, 3'd0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 16'h0080, 1, 0, 3'd0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 16'h0080, 1, 0, 3'd0, 0));
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 3'd0, 0));
      vecs.push_back(mk(0, 1, 8'h11, 1, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 3'd0, 0));
      vecs.push_back(mk(0, 1, 8'h22, 1, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 3'd0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'hAA, 1, 0, 16'h0000, 1, 0, 3'd2, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'hBB, 1, 1, 16'hAA11, 1, 0, 3'd2, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 16'hBB22, 1, 0, 3'd2, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, 16'hBB22, 1, 0, 3'd2, 0));
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 3'd0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h77, 1, 0, 16'h0000, 0, 0, 3'd0, 1));
      vecs.push_back(mk(0, 1, 8'h66, 1, 0, 8'h00, 1, 0, 16'h0000, 1, 0, 3'd1, 1));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 1, 16'h7766, 1, 0, 3'd1, 1));
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].stp, vecs[i].v0, vecs[i].b0, vecs[i].s0, vecs[i].v1, vecs[i].b1,
               vecs[i].s1);
         step();
         check($sformatf("vec%0d.word_valid", i), 32'(bus.word_valid), 32'(vecs[i].wv));
         check($sformatf("vec%0d.word_o", i), 32'(bus.word_o), 32'(vecs[i].w));
         check($sformatf("vec%0d.aligned", i), 32'(bus.aligned), 32'(vecs[i].al));
         check($sformatf("vec%0d.deskew_err", i), 32'(bus.deskew_err), 32'(vecs[i].err));
         check($sformatf("vec%0d.skew_o", i), 32'(bus.skew_o), 32'(vecs[i].skew));
         check($sformatf("vec%0d.lead_lane", i), 32'(bus.lead_lane), 32'(vecs[i].lead));
      end

      // Skew timeout: lane1 never rises within MAX_SKEW.
      drive(1, 0, 8'h00, 0, 0, 8'h00, 0); step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 8'(8'h40 + i), 1, 0, 8'h00, 0); step();
      end
      check("tmo.deskew_err", 32'(bus.deskew_err), 32'h1);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 8'h55, 1, 1, 8'h66, 1); step();
         check("tmo.word_valid", 32'(bus.word_valid), 32'h0);
         check("tmo.err_sticky", 32'(bus.deskew_err), 32'h1);
      end
      drive(1, 0, 8'h00, 1, 0, 8'h00, 1); step();
      check("tmo.stop_err", 32'(bus.deskew_err), 32'h0);
      drive(0, 0, 8'h00, 1, 0, 8'h00, 1); step();
      check("tmo.realign", 32'(bus.aligned), 32'h1);

      // Lane0 overflows while lane1 stays silent.
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 8'(i + 1), 1, 0, 8'h00, 1); step();
         check("ovf.word_valid", 32'(bus.word_valid), 32'h0);
         check($sformatf("ovf.err%0d", i), 32'(bus.deskew_err), (i == 4) ? 32'h1 : 32'h0);
      end

      // Pre-sync bytes are dropped; reset mid-stream leaves nothing stale.
      drive(1, 0, 8'h00, 0, 0, 8'h00, 0); step();
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 8'hFF, 0, 1, 8'hFF, 0); step();
      end
      drive(0, 0, 8'h00, 1, 0, 8'h00, 1); step();
      drive(0, 1, 8'h01, 1, 1, 8'h5C, 1); step();
      drive(0, 0, 8'h00, 1, 0, 8'h00, 1); step();
      check("pre.word_valid", 32'(bus.word_valid), 32'h1);
      check("pre.word_o", 32'(bus.word_o), 32'h5C01);
      step();
      check("pre.no_extra", 32'(bus.word_valid), 32'h0);
      drive(0, 1, 8'h91, 1, 0, 8'h00, 1); step();
      drive(0, 1, 8'h92, 1, 0, 8'h00, 1); step();
      reset = 1'b1;
      drive(0, 0, 8'h00, 0, 0, 8'h00, 0); step();
      check_all_zero("midrst");
      reset = 1'b0;
      drive(0, 1, 8'h33, 1, 1, 8'h44, 1); step();
      drive(0, 0, 8'h00, 1, 0, 8'h00, 1); step();
      check("midrst.word_o", 32'(bus.word_o), 32'h4433);
      check("midrst.word_valid", 32'(bus.word_valid), 32'h1);
      step();
      check("midrst.no_stale", 32'(bus.word_valid), 32'h0);

      // Random episodes: random skew/lead, random valid densities, occasional reset.
      for (int e = 0; e < 60; e++) begin
         int d, ld, pr0, pr1;
         drive(1, 0, 8'h00, 0, 0, 8'h00, 0); step();
         d   = int'($urandom_range(0, 3));
         ld  = int'($urandom_range(0, 1));
         pr0 = int'($urandom_range(1, 4));
         pr1 = int'($urandom_range(1, 4));
         for (int c = 0; c < 40; c++) begin
            drive(0, int'($urandom_range(0, 3)) < pr0, 8'($urandom), (ld == 1) ? (c >= d) : 1'b1,
                  int'($urandom_range(0, 3)) < pr1, 8'($urandom), (ld == 1) ? 1'b1 : (c >= d));
            reset = ($urandom_range(0, 99) == 0);
            step();
         end
         reset = 1'b0;
      end

`ifdef LANE_DESKEW_BYTECOUNT_EN
      drive(1, 0, 8'h00, 0, 0, 8'h00, 0); step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 8'(i), 1, 1, 8'(i), 1); step();
      end
      drive(0, 0, 8'h00, 1, 0, 8'h00, 1); step(); step();
      check("bc.three_words", 32'(bus.byte_count), 32'd6);
      for (int i = 0; i < 32764; i++) begin
         drive(0, 1, 8'(i), 1, 1, 8'(i), 1); step();
      end
      drive(0, 0, 8'h00, 1, 0, 8'h00, 1); step(); step();
      check("bc.fffe", 32'(bus.byte_count), 32'hFFFE);
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 8'(i), 1, 1, 8'(i), 1); step();
      end
      drive(0, 0, 8'h00, 1, 0, 8'h00, 1); step(); step();
      check("bc.saturate", 32'(bus.byte_count), 32'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
